// File: rtl/d_pipe_reg_if.sv
// Elastic handshake bundle for d_pipe_reg: upstream valid/ready, downstream valid/ready, flush and occupancy.
// With D_PIPE_PARITY_EN defined the bundle also carries inj_err and out_perr.
interface d_pipe_reg_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             flush;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] count;
`ifdef D_PIPE_PARITY_EN
  logic             inj_err;
  logic             out_perr;
`endif

  modport master (
    output flush,
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
`ifdef D_PIPE_PARITY_EN
    output inj_err,
    input  out_perr,
`endif
    input  count
  );

  modport slave (
    input  flush,
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
`ifdef D_PIPE_PARITY_EN
    input  inj_err,
    output out_perr,
`endif
    output count
  );
endinterface

// File: rtl/d_pipe_reg.sv
// DEPTH-stage elastic register pipeline with bubble collapsing, synchronous flush and occupancy count.
// Optional per-stage even parity is built when D_PIPE_PARITY_EN is defined.
module d_pipe_reg #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic        clk,
  input  logic        rst,
  d_pipe_reg_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_p [DEPTH];
  logic [DEPTH-1:0] vld_p;
  logic [DEPTH-1:0] vld_nxt;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic             in_rdy;
  logic             in_fire;

  function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  // Ready ripples back from the output: a stage moves if any stage ahead of it
  // is empty, or the whole run ahead is full and the output is being taken.
  always_comb begin
    logic go;
    adv = '0;
    go  = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i] = vld_p[i] & go;
      go     = ~vld_p[i] | adv[i];
    end
  end

  assign in_rdy  = (~vld_p[0] | adv[0]) & ~bus.flush;
  assign in_fire = bus.in_valid & in_rdy;

  always_comb begin
    load    = '0;
    load[0] = in_fire;
    for (int i = 1; i < DEPTH; i++) load[i] = adv[i-1] & ~bus.flush;
    vld_nxt = '0;
    if (!bus.flush) begin
      for (int i = 0; i < DEPTH; i++) vld_nxt[i] = load[i] | (vld_p[i] & ~adv[i]);
    end
  end

  // Stage valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p <= '0;
    else     vld_p <= vld_nxt;
  end

  // Stage data: loads only on a transfer into the stage, holds otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) data_p[i] <= RESET_VAL;
    end else begin
      if (load[0]) data_p[0] <= bus.in_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (load[i]) data_p[i] <= data_p[i-1];
      end
    end
  end

`ifdef D_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_p;

  // Parity travels with its word; inj_err corrupts it at the entry stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_p <= '0;
    end else begin
      if (load[0]) par_p[0] <= (^bus.in_data) ^ bus.inj_err;
      for (int i = 1; i < DEPTH; i++) begin
        if (load[i]) par_p[i] <= par_p[i-1];
      end
    end
  end

  assign bus.out_perr = vld_p[DEPTH-1] & ((^data_p[DEPTH-1]) ^ par_p[DEPTH-1]);
`endif

  assign bus.in_ready  = in_rdy;
  assign bus.out_data  = data_p[DEPTH-1];
  assign bus.out_valid = vld_p[DEPTH-1];
  assign bus.count     = popcount(vld_p);

endmodule
